exibe_sequencia: RTL

//  Plays the stored game sequence back to the player, the output side of the round

---
 rtl/exibe_sequencia.sv | 128 ++++++++++++
 1 files changed

// File: rtl/exibe_sequencia.sv
// Sequence playback unit: walks ROM entries 0..limite, shows each on the LEDs
// for T_ON cycles followed by a T_OFF dark gap, then pulses pronto once.
module exibe_sequencia #(
    parameter int T_ON  = 50_000_000,
    parameter int T_OFF = 25_000_000,
    parameter int CNT_W = 27
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       parar,
    input  logic [3:0] limite,
    output logic [3:0] endereco,
    input  logic [3:0] dado,
    output logic [3:0] leds,
    output logic       exibindo,
    output logic       pronto,
    output logic [2:0] db_estado
);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        BUSCA   = 3'd1,
        ACESO   = 3'd2,
        APAGADO = 3'd3,
        FIM     = 3'd4
    } estado_t;

    // Timer compares against T-1 since it counts up from 0 on state entry.
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(T_ON - 1);
    localparam logic [CNT_W-1:0] OFF_LAST   = CNT_W'(T_OFF - 1);
    // BUSCA spans the address register plus the ROM's one-cycle read.
    localparam logic [CNT_W-1:0] BUSCA_LAST = CNT_W'(1);

    estado_t          estado_q, estado_d;
    logic [3:0]       end_q, end_d;
    logic [3:0]       leds_q, leds_d;
    logic [3:0]       lim_q, lim_d;
    logic [CNT_W-1:0] timer_q, timer_d;

    // State and datapath registers; reset acts immediately, even mid-sequence.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= OCIOSO;
            end_q    <= 4'd0;
            leds_q   <= 4'd0;
            lim_q    <= 4'd0;
            timer_q  <= '0;
        end else begin
            estado_q <= estado_d;
            end_q    <= end_d;
            leds_q   <= leds_d;
            lim_q    <= lim_d;
            timer_q  <= timer_d;
        end
    end

    // Next-state logic; parar overrides every state, endereco is held on abort.
    always_comb begin
        estado_d = estado_q;
        end_d    = end_q;
        leds_d   = leds_q;
        lim_d    = lim_q;
        timer_d  = timer_q + CNT_W'(1);

        if (parar) begin
            estado_d = OCIOSO;
            leds_d   = 4'd0;
            timer_d  = '0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    leds_d  = 4'd0;
                    timer_d = '0;
                    if (iniciar) begin
                        lim_d    = limite;
                        end_d    = 4'd0;
                        estado_d = BUSCA;
                    end
                end
                BUSCA: begin
                    if (timer_q == BUSCA_LAST) begin
                        leds_d   = dado;
                        timer_d  = '0;
                        estado_d = ACESO;
                    end
                end
                ACESO: begin
                    if (timer_q == ON_LAST) begin
                        leds_d   = 4'd0;
                        timer_d  = '0;
                        estado_d = APAGADO;
                    end
                end
                APAGADO: begin
                    leds_d = 4'd0;
                    if (timer_q == OFF_LAST) begin
                        timer_d = '0;
                        // Last-entry check precedes the increment so 15 never wraps.
                        if (end_q == lim_q) begin
                            estado_d = FIM;
                        end else begin
                            end_d    = end_q + 4'd1;
                            estado_d = BUSCA;
                        end
                    end
                end
                FIM: begin
                    leds_d   = 4'd0;
                    timer_d  = '0;
                    estado_d = OCIOSO;
                end
                default: begin
                    leds_d   = 4'd0;
                    timer_d  = '0;
                    estado_d = OCIOSO;
                end
            endcase
        end
    end

    assign endereco  = end_q;
    assign leds      = leds_q;
    assign exibindo  = (estado_q != OCIOSO);
    assign pronto    = (estado_q == FIM);
    assign db_estado = estado_q;

endmodule
